sram_req_tracker: RTL and testbench

Parametrised outstanding-request tracker and response filter placed between a pipeline stage and its sram-like port (instruction or data side). It accepts up to DEPTH requests before any response returns, and tags each accepted request in an in-order FIFO. On a pipeline flush (exception/eret) it marks every in-flight request as stale and silently consumes the stale responses. It generalises the fixed two-deep discard bookkeeping of the current core to arbitrary depth, and adds per-request tags, back-pressure and protocol-error detection.

---
 rtl/sram_req_tracker.sv | 181 ++++++++++++++++++
 tb/tb_sram_req_tracker.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_tracker.sv
// ---------------------------------------------------------------------------
// sram_req_tracker
//
// Sits between a pipeline stage and its sram-like port (instruction or data
// side). It tracks up to DEPTH requests that have been accepted downstream
// but not yet answered. Each accepted request's sideband tag is kept in an
// in-order FIFO, so every response carries the tag of the request it
// answers. A pipeline flush marks every in-flight request stale. The
// responses to stale requests are consumed silently and never reach the
// pipeline.
//
// Parameters:
//   DEPTH   maximum number of outstanding requests (>= 1)
//   DATA_W  data width
//   TAG_W   width of the sideband tag returned with each response (>= 1)
//   CW      (local) width of the outstanding/discard counters
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             pipeline flush; everything accepted up to and
//                     including this cycle becomes stale
//   up_req .. up_tag  upstream request fields plus the tag to return
//   up_addr_ok        request accepted this cycle
//   up_data_ok        live (non-stale) response valid this cycle
//   up_rdata          response data (straight from dn_rdata)
//   up_resp_tag       tag at the FIFO head (tag of the current response)
//   dn_req .. dn_wdata  downstream request fields
//   dn_addr_ok        downstream accepts the request
//   dn_data_ok        downstream response, returned in request order
//   dn_rdata          downstream response data
//   outstanding       accepted requests still waiting for a response
//   idle              no requests outstanding
//   proto_err         sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module sram_req_tracker #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,

  input  logic              up_req,
  input  logic              up_wr,
  input  logic [1:0]        up_size,
  input  logic [31:0]       up_addr,
  input  logic [3:0]        up_wstrb,
  input  logic [DATA_W-1:0] up_wdata,
  input  logic [TAG_W-1:0]  up_tag,
  output logic              up_addr_ok,
  output logic              up_data_ok,
  output logic [DATA_W-1:0] up_rdata,
  output logic [TAG_W-1:0]  up_resp_tag,

  output logic              dn_req,
  output logic              dn_wr,
  output logic [1:0]        dn_size,
  output logic [31:0]       dn_addr,
  output logic [3:0]        dn_wstrb,
  output logic [DATA_W-1:0] dn_wdata,
  input  logic              dn_addr_ok,
  input  logic              dn_data_ok,
  input  logic [DATA_W-1:0] dn_rdata,

  output logic [CW-1:0]     outstanding,
  output logic              idle,
  output logic              proto_err
);

  // A single-entry FIFO still needs a one-bit pointer so the index
  // expressions stay legal; that pointer simply never leaves zero.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    outstanding_q;
  logic [CW-1:0]    outstanding_next;
  logic [CW-1:0]    discard_cnt;
  logic             proto_err_q;

  logic             full;
  logic             accept;
  logic             ret;
  logic             drop;
  logic             stray;

  // Wrap-around increment. DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Request path. The request is forwarded with no added latency. It is
  // held off only when every tracking slot is in use, or while reset is
  // asserted, so that nothing slips through during the reset cycle.
  assign full       = (outstanding_q == CW'(DEPTH));
  assign dn_req     = up_req & ~full & ~reset;
  assign dn_wr      = up_wr;
  assign dn_size    = up_size;
  assign dn_addr    = up_addr;
  assign dn_wstrb   = up_wstrb;
  assign dn_wdata   = up_wdata;
  assign up_addr_ok = dn_addr_ok & dn_req;
  assign accept     = up_addr_ok;

  // Response path. A response counts only if something is outstanding.
  // While discard_cnt is non-zero, the response at the FIFO head belongs
  // to a request issued before the last flush, so it is dropped. A stray
  // response (nothing outstanding) is ignored and only flags proto_err.
  assign ret         = dn_data_ok & (outstanding_q != '0);
  assign drop        = ret & (discard_cnt != '0);
  assign stray       = dn_data_ok & (outstanding_q == '0);
  assign up_data_ok  = ret & ~drop & ~reset;
  assign up_rdata    = dn_rdata;
  assign up_resp_tag = tag_mem[rd_ptr];

  assign outstanding_next = outstanding_q + CW'(accept) - CW'(ret);

  assign outstanding = outstanding_q;
  assign idle        = (outstanding_q == '0);
  assign proto_err   = proto_err_q;

  // Tag FIFO. The request accepted this cycle pushes its tag at the write
  // pointer. The returning response pops the head. Push and pop can happen
  // in the same cycle. The storage is cleared on reset so that the head
  // tag reads zero after a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= up_tag;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (ret) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  // Outstanding and discard counters. On a flush, every request still
  // outstanding after this cycle's accept and return is stale. That
  // includes a request accepted in the flush cycle itself. A response
  // returned in the flush cycle was already judged with the old
  // discard_cnt, so it is not counted again. Recomputing from
  // outstanding_next makes repeated flushes idempotent and keeps
  // discard_cnt <= outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      discard_cnt   <= '0;
    end else begin
      outstanding_q <= outstanding_next;
      if (flush) begin
        discard_cnt <= outstanding_next;
      end else if (drop) begin
        discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  // Sticky protocol-error flag. It is set by a response that nothing was
  // waiting for, and only a reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if (stray) begin
      proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_tracker.sv
// ---------------------------------------------------------------------------
// tb_sram_req_tracker
//
// Self-checking bench for sram_req_tracker (DEPTH=4, DATA_W=32, TAG_W=4).
// The reference model is a scoreboard queue that holds one entry per
// accepted request. Each entry holds the request's tag and a stale bit.
// A flush marks every queued entry stale. A response pops the head and is
// expected live only if that entry is not stale.
// ---------------------------------------------------------------------------
module tb_sram_req_tracker;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              flush;
  logic              up_req;
  logic              up_wr;
  logic [1:0]        up_size;
  logic [31:0]       up_addr;
  logic [3:0]        up_wstrb;
  logic [DATA_W-1:0] up_wdata;
  logic [TAG_W-1:0]  up_tag;
  logic              up_addr_ok;
  logic              up_data_ok;
  logic [DATA_W-1:0] up_rdata;
  logic [TAG_W-1:0]  up_resp_tag;
  logic              dn_req;
  logic              dn_wr;
  logic [1:0]        dn_size;
  logic [31:0]       dn_addr;
  logic [3:0]        dn_wstrb;
  logic [DATA_W-1:0] dn_wdata;
  logic              dn_addr_ok;
  logic              dn_data_ok;
  logic [DATA_W-1:0] dn_rdata;
  logic [CW-1:0]     outstanding;
  logic              idle;
  logic              proto_err;

  sram_req_tracker #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .up_req     (up_req),
    .up_wr      (up_wr),
    .up_size    (up_size),
    .up_addr    (up_addr),
    .up_wstrb   (up_wstrb),
    .up_wdata   (up_wdata),
    .up_tag     (up_tag),
    .up_addr_ok (up_addr_ok),
    .up_data_ok (up_data_ok),
    .up_rdata   (up_rdata),
    .up_resp_tag(up_resp_tag),
    .dn_req     (dn_req),
    .dn_wr      (dn_wr),
    .dn_size    (dn_size),
    .dn_addr    (dn_addr),
    .dn_wstrb   (dn_wstrb),
    .dn_wdata   (dn_wdata),
    .dn_addr_ok (dn_addr_ok),
    .dn_data_ok (dn_data_ok),
    .dn_rdata   (dn_rdata),
    .outstanding(outstanding),
    .idle       (idle),
    .proto_err  (proto_err)
  );

  typedef struct packed {
    logic             stale;
    logic [TAG_W-1:0] tag;
  } sb_t;

  typedef struct packed {
    logic             fl;
    logic             rq;
    logic [TAG_W-1:0] tg;
    logic             aok;
    logic             dok;
  } stim_t;

  sb_t   sb[$];
  stim_t tbl[$];

  int n_cmp;
  int n_bad;

  logic             m_proto;
  logic             exp_dn_req;
  logic             exp_addr_ok;
  logic             exp_ret;
  logic             exp_data_ok;
  logic [TAG_W-1:0] exp_tag;

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net: the bench must never run away.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input logic fl, input logic rq, input int tg,
                               input logic aok, input logic dok);
    return {fl, rq, TAG_W'(tg), aok, dok};
  endfunction

  // Drive one cycle of stimulus at the falling edge. Then derive the
  // expected combinational outputs from the scoreboard, and update the
  // scoreboard for the coming rising edge.
  task automatic apply_stimulus(input stim_t s);
    sb_t head;
    @(negedge clk);
    flush      = s.fl;
    up_req     = s.rq;
    up_tag     = s.tg;
    up_wr      = 1'($urandom_range(0, 1));
    up_size    = 2'($urandom_range(0, 3));
    up_addr    = $urandom;
    up_wstrb   = 4'($urandom_range(0, 15));
    up_wdata   = $urandom;
    dn_addr_ok = s.aok;
    dn_data_ok = s.dok;
    dn_rdata   = $urandom;
    #1;
    exp_dn_req  = s.rq && (sb.size() < DEPTH);
    exp_addr_ok = exp_dn_req && s.aok;
    exp_ret     = s.dok && (sb.size() != 0);
    exp_data_ok = 1'b0;
    exp_tag     = '0;
    if (s.dok && sb.size() == 0) m_proto = 1'b1;
    if (exp_ret) begin
      head        = sb.pop_front();
      exp_data_ok = ~head.stale;
      exp_tag     = head.tag;
    end
    if (exp_addr_ok) sb.push_back({1'b0, s.tg});
    if (s.fl) begin
      for (int k = 0; k < sb.size(); k++) sb[k].stale = 1'b1;
    end
  endtask

  // Reset with requests and a response pending on the inputs. Nothing may
  // leave the tracker during reset. Afterwards everything reads its reset
  // value.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; up_req = 1'b1; dn_addr_ok = 1'b1; dn_data_ok = 1'b1;
    #1;
    n_cmp++; if (dn_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_dn_req: got %b expected 0", dn_req); end
    n_cmp++; if (up_addr_ok !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_addr_ok: got %b expected 0", up_addr_ok); end
    n_cmp++; if (up_data_ok !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_data_ok: got %b expected 0", up_data_ok); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; up_req = 1'b0; dn_addr_ok = 1'b0; dn_data_ok = 1'b0;
    #1;
    sb.delete();
    m_proto = 1'b0;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_idle: got %b expected 1", idle); end
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_proto_err: got %b expected 0", proto_err); end
    n_cmp++; if (up_resp_tag !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_resp_tag: got %0d expected 0", up_resp_tag); end
  endtask

  // Three requests, responses three cycles after issue. The tags must come
  // back 1,2,3 in order, and the fields must pass straight through.
  task automatic test_basic();
    logic [TAG_W-1:0] want [3];
    logic [TAG_W-1:0] got [$];
    int peak;
    want[0] = 4'd1; want[1] = 4'd2; want[2] = 4'd3;
    peak = 0;
    tbl.delete();
    tbl.push_back(mk(0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 1, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      n_cmp++; if (dn_req !== exp_dn_req) begin n_bad++; $display("[TB] FAIL basic_dn_req[%0d]: got %b expected %b", i, dn_req, exp_dn_req); end
      n_cmp++; if (up_addr_ok !== exp_addr_ok) begin n_bad++; $display("[TB] FAIL basic_addr_ok[%0d]: got %b expected %b", i, up_addr_ok, exp_addr_ok); end
      n_cmp++; if (up_data_ok !== exp_data_ok) begin n_bad++; $display("[TB] FAIL basic_data_ok[%0d]: got %b expected %b", i, up_data_ok, exp_data_ok); end
      if (exp_data_ok) begin
        n_cmp++; if (up_resp_tag !== exp_tag) begin n_bad++; $display("[TB] FAIL basic_tag[%0d]: got %0d expected %0d", i, up_resp_tag, exp_tag); end
      end
      n_cmp++; if (dn_addr !== up_addr || dn_wdata !== up_wdata || dn_wr !== up_wr || dn_size !== up_size || dn_wstrb !== up_wstrb)
        begin n_bad++; $display("[TB] FAIL basic_passthru[%0d]: got addr %h expected %h", i, dn_addr, up_addr); end
      n_cmp++; if (up_rdata !== dn_rdata) begin n_bad++; $display("[TB] FAIL basic_rdata[%0d]: got %h expected %h", i, up_rdata, dn_rdata); end
      if (up_data_ok === 1'b1) got.push_back(up_resp_tag);
      @(posedge clk); #1;
      n_cmp++; if (outstanding !== CW'(sb.size())) begin n_bad++; $display("[TB] FAIL basic_outstanding[%0d]: got %0d expected %0d", i, outstanding, sb.size()); end
      if (int'(outstanding) > peak) peak = int'(outstanding);
    end
    n_cmp++; if (peak != 3) begin n_bad++; $display("[TB] FAIL basic_peak: got %0d expected 3", peak); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_idle: got %b expected 1", idle); end
    n_cmp++;
    if (got.size() != 3) begin
      n_bad++; $display("[TB] FAIL basic_live_count: got %0d expected 3", got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (got[j] !== want[j]) begin n_bad++; $display("[TB] FAIL basic_order[%0d]: got %0d expected %0d", j, got[j], want[j]); end
      end
    end
  endtask

  // Fill all four slots. Then dn_req must stay low while up_req is high.
  // A response frees a slot for the following cycle.
  task automatic test_back_pressure();
    tbl.delete();
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 1, 8 + k, 1, 0));
    tbl.push_back(mk(0, 1, 12, 1, 0));
    tbl.push_back(mk(0, 1, 12, 1, 1));
    tbl.push_back(mk(0, 1, 12, 1, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      n_cmp++; if (dn_req !== exp_dn_req) begin n_bad++; $display("[TB] FAIL bp_dn_req[%0d]: got %b expected %b", i, dn_req, exp_dn_req); end
      n_cmp++; if (up_addr_ok !== exp_addr_ok) begin n_bad++; $display("[TB] FAIL bp_addr_ok[%0d]: got %b expected %b", i, up_addr_ok, exp_addr_ok); end
      n_cmp++; if (up_data_ok !== exp_data_ok) begin n_bad++; $display("[TB] FAIL bp_data_ok[%0d]: got %b expected %b", i, up_data_ok, exp_data_ok); end
      if (exp_data_ok) begin
        n_cmp++; if (up_resp_tag !== exp_tag) begin n_bad++; $display("[TB] FAIL bp_tag[%0d]: got %0d expected %0d", i, up_resp_tag, exp_tag); end
      end
      if (i == 4 || i == 5) begin
        n_cmp++; if (dn_req !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_full_hold[%0d]: got %b expected 0", i, dn_req); end
      end
      if (i == 6) begin
        n_cmp++; if (dn_req !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_slot_freed: got %b expected 1", dn_req); end
      end
      @(posedge clk); #1;
      n_cmp++; if (outstanding !== CW'(sb.size())) begin n_bad++; $display("[TB] FAIL bp_outstanding[%0d]: got %0d expected %0d", i, outstanding, sb.size()); end
      if (i == 3) begin
        n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("[TB] FAIL bp_full_count: got %0d expected 4", outstanding); end
      end
    end
  endtask

  // Flush with three requests in flight. Their three responses vanish.
  // Tag 7, issued after the flush, still comes back live.
  task automatic test_flush();
    int n_live;
    int n_drop;
    logic [TAG_W-1:0] last_tag;
    n_live = 0; n_drop = 0; last_tag = '0;
    tbl.delete();
    tbl.push_back(mk(0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 1, 3, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      n_cmp++; if (dn_req !== exp_dn_req) begin n_bad++; $display("[TB] FAIL flush_dn_req[%0d]: got %b expected %b", i, dn_req, exp_dn_req); end
      n_cmp++; if (up_addr_ok !== exp_addr_ok) begin n_bad++; $display("[TB] FAIL flush_addr_ok[%0d]: got %b expected %b", i, up_addr_ok, exp_addr_ok); end
      n_cmp++; if (up_data_ok !== exp_data_ok) begin n_bad++; $display("[TB] FAIL flush_data_ok[%0d]: got %b expected %b", i, up_data_ok, exp_data_ok); end
      if (exp_data_ok) begin
        n_cmp++; if (up_resp_tag !== exp_tag) begin n_bad++; $display("[TB] FAIL flush_tag[%0d]: got %0d expected %0d", i, up_resp_tag, exp_tag); end
      end
      if (dn_data_ok && up_data_ok === 1'b1) begin n_live++; last_tag = up_resp_tag; end
      if (dn_data_ok && up_data_ok === 1'b0) n_drop++;
      @(posedge clk); #1;
      n_cmp++; if (outstanding !== CW'(sb.size())) begin n_bad++; $display("[TB] FAIL flush_outstanding[%0d]: got %0d expected %0d", i, outstanding, sb.size()); end
    end
    n_cmp++; if (n_drop != 3) begin n_bad++; $display("[TB] FAIL flush_drops: got %0d expected 3", n_drop); end
    n_cmp++; if (n_live != 1) begin n_bad++; $display("[TB] FAIL flush_lives: got %0d expected 1", n_live); end
    n_cmp++; if (last_tag !== 4'd7) begin n_bad++; $display("[TB] FAIL flush_live_tag: got %0d expected 7", last_tag); end
  endtask

  // Flush, accept and return all land in one cycle. The return is judged
  // with the pre-flush state, so tag 1 is live. Tags 2 and 5 are then
  // dropped, and tag 6 afterwards is live.
  task automatic test_flush_corner();
    int n_drop;
    n_drop = 0;
    tbl.delete();
    tbl.push_back(mk(0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 1, 0));
    tbl.push_back(mk(1, 1, 5, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 6, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      n_cmp++; if (dn_req !== exp_dn_req) begin n_bad++; $display("[TB] FAIL corner_dn_req[%0d]: got %b expected %b", i, dn_req, exp_dn_req); end
      n_cmp++; if (up_addr_ok !== exp_addr_ok) begin n_bad++; $display("[TB] FAIL corner_addr_ok[%0d]: got %b expected %b", i, up_addr_ok, exp_addr_ok); end
      n_cmp++; if (up_data_ok !== exp_data_ok) begin n_bad++; $display("[TB] FAIL corner_data_ok[%0d]: got %b expected %b", i, up_data_ok, exp_data_ok); end
      if (exp_data_ok) begin
        n_cmp++; if (up_resp_tag !== exp_tag) begin n_bad++; $display("[TB] FAIL corner_tag[%0d]: got %0d expected %0d", i, up_resp_tag, exp_tag); end
      end
      if (i == 2) begin
        n_cmp++; if (up_data_ok !== 1'b1 || up_resp_tag !== 4'd1) begin n_bad++; $display("[TB] FAIL corner_flush_cycle_live: got ok=%b tag=%0d expected ok=1 tag=1", up_data_ok, up_resp_tag); end
      end
      if (i == 6) begin
        n_cmp++; if (up_data_ok !== 1'b1 || up_resp_tag !== 4'd6) begin n_bad++; $display("[TB] FAIL corner_after_live: got ok=%b tag=%0d expected ok=1 tag=6", up_data_ok, up_resp_tag); end
      end
      if (dn_data_ok && up_data_ok === 1'b0) n_drop++;
      @(posedge clk); #1;
      n_cmp++; if (outstanding !== CW'(sb.size())) begin n_bad++; $display("[TB] FAIL corner_outstanding[%0d]: got %0d expected %0d", i, outstanding, sb.size()); end
    end
    n_cmp++; if (n_drop != 2) begin n_bad++; $display("[TB] FAIL corner_drops: got %0d expected 2", n_drop); end
  endtask

  // Flush, drop one response, then flush again together with a new
  // accept. The second flush must not double-count, so exactly two more
  // drops follow, then one live response (tag 4).
  task automatic test_double_flush();
    int n_drop;
    int n_live;
    n_drop = 0; n_live = 0;
    tbl.delete();
    tbl.push_back(mk(0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1));
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      n_cmp++; if (dn_req !== exp_dn_req) begin n_bad++; $display("[TB] FAIL dflush_dn_req[%0d]: got %b expected %b", i, dn_req, exp_dn_req); end
      n_cmp++; if (up_addr_ok !== exp_addr_ok) begin n_bad++; $display("[TB] FAIL dflush_addr_ok[%0d]: got %b expected %b", i, up_addr_ok, exp_addr_ok); end
      n_cmp++; if (up_data_ok !== exp_data_ok) begin n_bad++; $display("[TB] FAIL dflush_data_ok[%0d]: got %b expected %b", i, up_data_ok, exp_data_ok); end
      if (exp_data_ok) begin
        n_cmp++; if (up_resp_tag !== exp_tag) begin n_bad++; $display("[TB] FAIL dflush_tag[%0d]: got %0d expected %0d", i, up_resp_tag, exp_tag); end
      end
      if (dn_data_ok && up_data_ok === 1'b0) n_drop++;
      if (dn_data_ok && up_data_ok === 1'b1) n_live++;
      @(posedge clk); #1;
      n_cmp++; if (outstanding !== CW'(sb.size())) begin n_bad++; $display("[TB] FAIL dflush_outstanding[%0d]: got %0d expected %0d", i, outstanding, sb.size()); end
    end
    n_cmp++; if (n_drop != 3) begin n_bad++; $display("[TB] FAIL dflush_drops: got %0d expected 3", n_drop); end
    n_cmp++; if (n_live != 1) begin n_bad++; $display("[TB] FAIL dflush_lives: got %0d expected 1", n_live); end
  endtask

  // A stray response at idle raises proto_err. A reset in the middle of a
  // burst clears everything. A later stray response raises the flag again.
  task automatic test_proto_reset();
    tbl.delete();
    tbl.push_back(mk(0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 9, 1, 0));
    tbl.push_back(mk(0, 1, 10, 1, 0));
    tbl.push_back(mk(0, 1, 11, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      n_cmp++; if (dn_req !== exp_dn_req) begin n_bad++; $display("[TB] FAIL proto_dn_req[%0d]: got %b expected %b", i, dn_req, exp_dn_req); end
      n_cmp++; if (up_data_ok !== exp_data_ok) begin n_bad++; $display("[TB] FAIL proto_data_ok[%0d]: got %b expected %b", i, up_data_ok, exp_data_ok); end
      @(posedge clk); #1;
      n_cmp++; if (proto_err !== m_proto) begin n_bad++; $display("[TB] FAIL proto_flag[%0d]: got %b expected %b", i, proto_err, m_proto); end
      n_cmp++; if (outstanding !== CW'(sb.size())) begin n_bad++; $display("[TB] FAIL proto_outstanding[%0d]: got %0d expected %0d", i, outstanding, sb.size()); end
    end
    n_cmp++; if (outstanding !== 3'd3) begin n_bad++; $display("[TB] FAIL proto_burst_count: got %0d expected 3", outstanding); end

    @(negedge clk);
    reset = 1'b1; flush = 1'b0; up_req = 1'b1; dn_addr_ok = 1'b1; dn_data_ok = 1'b0;
    #1;
    n_cmp++; if (dn_req !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_dn_req: got %b expected 0", dn_req); end
    n_cmp++; if (up_addr_ok !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_addr_ok: got %b expected 0", up_addr_ok); end
    @(negedge clk);
    reset = 1'b0; up_req = 1'b0; dn_addr_ok = 1'b0;
    #1;
    sb.delete();
    m_proto = 1'b0;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("[TB] FAIL midreset_outstanding: got %0d expected 0", outstanding); end
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_proto_err: got %b expected 0", proto_err); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("[TB] FAIL midreset_idle: got %b expected 1", idle); end

    apply_stimulus(mk(0, 0, 0, 0, 1));
    n_cmp++; if (up_data_ok !== 1'b0) begin n_bad++; $display("[TB] FAIL stray_data_ok: got %b expected 0", up_data_ok); end
    @(posedge clk); #1;
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("[TB] FAIL stray_proto_err: got %b expected 1", proto_err); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("[TB] FAIL stray_outstanding: got %0d expected 0", outstanding); end
  endtask

  // Test sequence.
  initial begin
    n_cmp = 0; n_bad = 0; m_proto = 1'b0;
    reset = 1'b1; flush = 1'b0; up_req = 1'b0; up_wr = 1'b0; up_size = '0;
    up_addr = '0; up_wstrb = '0; up_wdata = '0; up_tag = '0;
    dn_addr_ok = 1'b0; dn_data_ok = 1'b0; dn_rdata = '0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_flush();
    test_flush_corner();
    test_double_flush();
    test_proto_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
